// File: rtl/matriz_leitura.sv
// Captures a 5x5 matrix of bytes and streams it out row-major over a valid/ready handshake.
// Optional macro LEITURA_TAMANHO_EN adds the tamanho port to select an active NxN region (N=2..5).
module matriz_leitura (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_leitura,
    input  logic [199:0] matriz_in,
`ifdef LEITURA_TAMANHO_EN
    input  logic [1:0]   tamanho,
`endif
    output logic [7:0]   dado_out,
    output logic [2:0]   linha_out,
    output logic [2:0]   coluna_out,
    output logic         dado_valido,
    input  logic         dado_pronto,
    output logic         ocupado,
    output logic         done_leitura
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENVIA = 2'd1,
        FIM   = 2'd2
    } estado_t;

    estado_t        estado, estado_n;
    logic [199:0]   mat_q;
    logic [2:0]     lim_q;
    logic           captura;
    logic           transf;
    logic           ultimo;
    logic [2:0]     linha_n;
    logic [2:0]     coluna_n;

    function automatic logic [7:0] elem(input logic [199:0] m,
                                        input logic [2:0]   r,
                                        input logic [2:0]   c);
        logic [7:0] idx;
        idx = 8'(40 * int'(r) + 8 * int'(c));
        return m[idx +: 8];
    endfunction

`ifndef LEITURA_TAMANHO_EN
    assign lim_q = 3'd4;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_n;
        end
    end

    always_comb begin
        estado_n = estado;
        captura  = 1'b0;
        transf   = dado_valido && dado_pronto;
        ultimo   = (linha_out == lim_q) && (coluna_out == lim_q);
        linha_n  = linha_out;
        coluna_n = coluna_out;
        if (coluna_out == lim_q) begin
            coluna_n = 3'd0;
            linha_n  = linha_out + 3'd1;
        end else begin
            coluna_n = coluna_out + 3'd1;
        end
        case (estado)
            IDLE: begin
                if (start_leitura) begin
                    captura  = 1'b1;
                    estado_n = ENVIA;
                end
            end
            ENVIA: begin
                if (transf && ultimo) begin
                    estado_n = FIM;
                end
            end
            FIM: begin
                estado_n = IDLE;
            end
            default: begin
                estado_n = IDLE;
            end
        endcase
    end

    // Output registers: element for the next transfer is looked up one edge ahead
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mat_q        <= '0;
            dado_out     <= '0;
            linha_out    <= '0;
            coluna_out   <= '0;
            dado_valido  <= 1'b0;
            ocupado      <= 1'b0;
            done_leitura <= 1'b0;
`ifdef LEITURA_TAMANHO_EN
            lim_q        <= 3'd4;
`endif
        end else begin
            done_leitura <= 1'b0;
            if (captura) begin
                mat_q       <= matriz_in;
                dado_out    <= matriz_in[7:0];
                linha_out   <= 3'd0;
                coluna_out  <= 3'd0;
                dado_valido <= 1'b1;
                ocupado     <= 1'b1;
`ifdef LEITURA_TAMANHO_EN
                lim_q       <= {1'b0, tamanho} + 3'd1;
`endif
            end else if (estado == ENVIA && transf) begin
                if (ultimo) begin
                    dado_valido  <= 1'b0;
                    done_leitura <= 1'b1;
                end else begin
                    linha_out  <= linha_n;
                    coluna_out <= coluna_n;
                    dado_out   <= elem(mat_q, linha_n, coluna_n);
                end
            end else if (estado == FIM) begin
                ocupado <= 1'b0;
            end
        end
    end

endmodule

// File: doc/matriz_leitura.md
MATRIZ_LEITURA -- requirements
Module: matriz_leitura

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 start_leitura  input  1  request to capture matriz_in and stream it out; honoured only in IDLE.
REQ-005 matriz_in  input  200  5x5 matrix of 8-bit elements; element (r,c) at bits [40*r+8*c +: 8], r = row, c = column, both 0..4.
REQ-006 tamanho  input  2  active size select, present only with LEITURA_TAMANHO_EN: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
REQ-007 dado_out  output  8  current element.
REQ-008 linha_out  output  3  row index of dado_out.
REQ-009 coluna_out  output  3  column index of dado_out.
REQ-010 dado_valido  output  1  dado_out, linha_out and coluna_out are valid.
REQ-011 dado_pronto  input  1  consumer accepts the element; a transfer occurs on a cycle with dado_valido=1 and dado_pronto=1.
REQ-012 ocupado  output  1  high in ENVIA and FIM.
REQ-013 done_leitura  output  1  one-cycle pulse after the last transfer.

Function
REQ-014 FSM states SHALL be IDLE, ENVIA and FIM, with IDLE as the reset state.
REQ-015 IDLE with start_leitura=1: capture matriz_in into an internal 200-bit register, and tamanho when compiled in; set r=0, c=0; go to ENVIA on the next edge.
REQ-016 Changes to matriz_in after capture SHALL NOT affect streamed data.
REQ-017 In ENVIA, dado_valido=1, dado_out=captured element (r,c), linha_out=r and coluna_out=c; all outputs are registered.
REQ-018 With dado_valido=1 and dado_pronto=0, dado_out, linha_out and coluna_out SHALL hold stable.
REQ-019 On a transfer with c<N-1: c increments.
REQ-020 On a transfer with c=N-1 and r<N-1: c wraps to 0 and r increments (row-major order).
REQ-021 On a transfer at (N-1,N-1): go to FIM, and dado_valido=0 on the next cycle.
REQ-022 FIM SHALL assert done_leitura=1 for exactly one cycle, then return to IDLE.
REQ-023 start_leitura SHALL be ignored in ENVIA and FIM; a new start is accepted only in IDLE.
REQ-024 Latency: the first element is valid one cycle after the start edge; with dado_pronto held high, N*N transfers occur on consecutive cycles and done_leitura asserts N*N+1 cycles after the start edge.
REQ-025 dado_pronto SHALL have no effect while dado_valido=0.
REQ-026 Elements outside the active NxN region SHALL never be output.

Reset
REQ-027 When rst_n=0 at a clk edge, the block SHALL enter IDLE and set dado_out=0, linha_out=0, coluna_out=0, dado_valido=0, ocupado=0, done_leitura=0 and the internal register to 0.
REQ-028 A reset during ENVIA or FIM SHALL abort the stream with no done_leitura pulse.
REQ-029 A start_leitura coinciding with rst_n=0 SHALL be ignored.

Configuration
REQ-030 Macro LEITURA_TAMANHO_EN defined: the tamanho port exists, it is sampled with the start, and N=tamanho+2.
REQ-031 Macro LEITURA_TAMANHO_EN undefined: the tamanho port is absent and N=5 fixed.

Verification
REQ-032 Element (r,c)=10*r+c, dado_pronto=1, start -> 25 elements 0x00,0x01..0x04,0x0A..0x2C in row-major order with indices, and done_leitura exactly 26 cycles after start.
REQ-033 Same matrix with dado_pronto toggling 1,0 -> 25 transfers only on ready cycles, outputs stable during stalls, done after the 25th transfer.
REQ-034 Change matriz_in and pulse start_leitura during ENVIA -> stream unchanged, no restart, single done.
REQ-035 rst_n=0 after the 7th transfer -> next cycle: all outputs 0, IDLE, no done; a new start streams from (0,0).
REQ-036 With LEITURA_TAMANHO_EN and tamanho=01 -> exactly 9 elements (0,0)..(2,2): 0x00,0x01,0x02,0x0A..0x16; done 10 cycles after start with ready high.
REQ-037 Start held high across FIM -> exactly one done pulse, then a new capture on the first IDLE cycle.
